// File: rtl/pwm_define.sv
// pwm_define: shared types and defaults for the PWM blocks
// Contents: DT_WIDTH_DEF (default dead-time counter width), dt_state_e (dead-time FSM states)
package pwm_define;
    localparam int DT_WIDTH_DEF = 8;
    typedef enum logic [2:0] {
        OFF  = 3'd0,
        DB_H = 3'd1,
        ON_H = 3'd2,
        DB_L = 3'd3,
        ON_L = 3'd4
    } dt_state_e;
endpackage

// File: rtl/pwm_deadtime_chnl.sv
// pwm_deadtime_chnl: one channel of dead-time insertion (input register, FSM, dead-band counter)
// Ports: clk_i, rst_n_i (async, active-low), en_i, pwm_i, dt_rise_i, dt_fall_i,
//        pwm_h_o / pwm_l_o (registered gate drives), dt_act_o (in a dead band)
module pwm_deadtime_chnl
    import pwm_define::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                pwm_i,
    input  logic [DT_WIDTH-1:0] dt_rise_i,
    input  logic [DT_WIDTH-1:0] dt_fall_i,
    output logic                pwm_h_o,
    output logic                pwm_l_o,
    output logic                dt_act_o
);
    logic                pwm_q;
    dt_state_e           state, state_d;
    logic [DT_WIDTH-1:0] cnt, cnt_d;
    logic                go_h, go_l, in_db;
    assign go_h  = pwm_q && (state inside {OFF, DB_L, ON_L});
    assign go_l  = !pwm_q && (state inside {OFF, DB_H, ON_H});
    assign in_db = state == DB_H || state == DB_L;
    // The band leaves on the edge where cnt reaches 1, so the new side turns on dt edges after entry.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (!en_i) begin
            state_d = OFF;
            cnt_d   = '0;
        end else if (go_h) begin
            state_d = dt_rise_i == '0 ? ON_H : DB_H;
            cnt_d   = dt_rise_i;
        end else if (go_l) begin
            state_d = dt_fall_i == '0 ? ON_L : DB_L;
            cnt_d   = dt_fall_i;
        end else if (in_db) begin
            state_d = cnt > DT_WIDTH'(1) ? state : (state == DB_H ? ON_H : ON_L);
            cnt_d   = cnt > DT_WIDTH'(1) ? cnt - DT_WIDTH'(1) : '0;
        end
    end
    // Outputs are registered from the next state so the drives are glitch-free flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pwm_q    <= 1'b0;
            state    <= OFF;
            cnt      <= '0;
            pwm_h_o  <= 1'b0;
            pwm_l_o  <= 1'b0;
            dt_act_o <= 1'b0;
        end else begin
            pwm_q    <= pwm_i;
            state    <= state_d;
            cnt      <= cnt_d;
            pwm_h_o  <= state_d == ON_H;
            pwm_l_o  <= state_d == ON_L;
            dt_act_o <= state_d == DB_H || state_d == DB_L;
        end
    end
endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary gate drives with programmable dead band for CHNL_NUM PWM channels
// Ports: clk_i, rst_n_i (async, active-low), en_i / pwm_i (per channel), dt_rise_i / dt_fall_i (shared),
//        pol_i (only with PWM_DEADTIME_POL_EN: bit 2c inverts high side, 2c+1 low side),
//        pwm_h_o, pwm_l_o, dt_act_o (per channel)
module pwm_deadtime
    import pwm_define::*;
#(
    parameter int CHNL_NUM = 4,
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [CHNL_NUM-1:0]   en_i,
    input  logic [CHNL_NUM-1:0]   pwm_i,
    input  logic [DT_WIDTH-1:0]   dt_rise_i,
    input  logic [DT_WIDTH-1:0]   dt_fall_i,
`ifdef PWM_DEADTIME_POL_EN
    input  logic [2*CHNL_NUM-1:0] pol_i,
`endif
    output logic [CHNL_NUM-1:0]   pwm_h_o,
    output logic [CHNL_NUM-1:0]   pwm_l_o,
    output logic [CHNL_NUM-1:0]   dt_act_o
);
    logic [CHNL_NUM-1:0] h, l;
    for (genvar c = 0; c < CHNL_NUM; c++) begin : g_chnl
        pwm_deadtime_chnl #(.DT_WIDTH(DT_WIDTH)) u_chnl (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .en_i     (en_i[c]),
            .pwm_i    (pwm_i[c]),
            .dt_rise_i(dt_rise_i),
            .dt_fall_i(dt_fall_i),
            .pwm_h_o  (h[c]),
            .pwm_l_o  (l[c]),
            .dt_act_o (dt_act_o[c])
        );
`ifdef PWM_DEADTIME_POL_EN
        // Polarity is applied after the flops so it adds no latency.
        assign pwm_h_o[c] = h[c] ^ pol_i[2*c];
        assign pwm_l_o[c] = l[c] ^ pol_i[2*c+1];
`else
        assign pwm_h_o[c] = h[c];
        assign pwm_l_o[c] = l[c];
`endif
    end
endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: scoreboard bench for pwm_deadtime against a run-length reference model
module tb_pwm_deadtime;
    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [N-1:0] h;
        logic [N-1:0] l;
        logic [N-1:0] a;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [N-1:0]  en_i = '0;
    logic [N-1:0]  pwm_i = '0;
    logic [DW-1:0] dt_rise_i = 8'd3;
    logic [DW-1:0] dt_fall_i = 8'd5;
    logic [N-1:0]  pwm_h_o, pwm_l_o, dt_act_o;
    logic [N-1:0]  pol_h, pol_l;
`ifdef PWM_DEADTIME_POL_EN
    logic [2*N-1:0] pol_i;
    initial pol_i = {6'($urandom), 2'b10};
    always_comb for (int c = 0; c < N; c++) begin
        pol_h[c] = pol_i[2*c];
        pol_l[c] = pol_i[2*c+1];
    end
`else
    assign pol_h = '0;
    assign pol_l = '0;
`endif

    pwm_deadtime #(.CHNL_NUM(N), .DT_WIDTH(DW)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (en_i),
        .pwm_i    (pwm_i),
        .dt_rise_i(dt_rise_i),
        .dt_fall_i(dt_fall_i),
`ifdef PWM_DEADTIME_POL_EN
        .pol_i    (pol_i),
`endif
        .pwm_h_o  (pwm_h_o),
        .pwm_l_o  (pwm_l_o),
        .dt_act_o (dt_act_o)
    );

    always #5 clk_i = ~clk_i;

    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: each enabled channel is in a "run" toward the side pwm_q asks for.
    // A run restarts on enable or when the requested side changes, and latches its dead time.
    // The side is driven once the run is longer than its dead time; before that it is a dead band.
    logic pq[N];
    logic side[N];
    int   len[N];
    int   rdt[N];
    initial for (int c = 0; c < N; c++) begin
        pq[c] = 0; side[c] = 0; len[c] = 0; rdt[c] = 0;
    end
    always @(posedge clk_i) begin
        exp_t e;
        logic p;
        for (int c = 0; c < N; c++) begin
            p = pq[c];
            pq[c] = pwm_i[c];
            if (!rst_n_i) begin
                pq[c] = 0;
                len[c] = 0;
            end else if (!en_i[c]) begin
                len[c] = 0;
            end else if (len[c] == 0 || p != side[c]) begin
                side[c] = p;
                len[c] = 1;
                rdt[c] = p ? int'(dt_rise_i) : int'(dt_fall_i);
            end else if (len[c] < 1000) begin
                len[c]++;
            end
            e.h[c] = len[c] > 0 && side[c] && len[c] > rdt[c];
            e.l[c] = len[c] > 0 && !side[c] && len[c] > rdt[c];
            e.a[c] = len[c] > 0 && len[c] <= rdt[c];
        end
        sb.push_back(e);
    end

    // Monitor: samples outputs just after each active edge and checks them against the scoreboard.
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected >0", $time);
        end else begin
            e = sb.pop_front();
            chk("pwm_h", pwm_h_o ^ pol_h, e.h);
            chk("pwm_l", pwm_l_o ^ pol_l, e.l);
            chk("dt_act", dt_act_o, e.a);
            chk("h_l_overlap", (pwm_h_o ^ pol_h) & (pwm_l_o ^ pol_l), '0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        cyc(3);
        rst_n_i = 1'b1;
        en_i = '1;
        repeat (2) begin
            pwm_i = '1; cyc(20);
            pwm_i = '0; cyc(20);
        end
        dt_rise_i = 8'd0; dt_fall_i = 8'd0;
        pwm_i = '1; cyc(20);
        pwm_i = '0; cyc(20);
        dt_rise_i = 8'd8; dt_fall_i = 8'd5;
        cyc(10);
        pwm_i = '1; cyc(4);
        pwm_i = '0; cyc(15);
        pwm_i = '1; cyc(4);
        en_i = '0; cyc(3);
        pwm_i = '0; cyc(2);
        en_i = '1; cyc(12);
        pwm_i = '1; cyc(4);
        #2 rst_n_i = 1'b0;
        #1;
        chk("async_rst_h", pwm_h_o ^ pol_h, '0);
        chk("async_rst_l", pwm_l_o ^ pol_l, '0);
        chk("async_rst_act", dt_act_o, '0);
        cyc(2);
        rst_n_i = 1'b1;
        cyc(20);
        pwm_i = '0; cyc(12);
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(7) == 0) pwm_i[c] = ~pwm_i[c];
            if ($urandom_range(59) == 0) en_i[$urandom_range(N-1)] ^= 1'b1;
            if ($urandom_range(29) == 0) dt_rise_i = DW'($urandom_range(6));
            if ($urandom_range(29) == 0) dt_fall_i = DW'($urandom_range(6));
            cyc(1);
        end
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Per-channel dead-time inserter, downstream of apb4_pwm.
- Consumes the raw PWM channel outputs and produces complementary high-side/low-side gate drives.
- A programmable dead band, with both sides off, is inserted on every transition.
- Sits between the PWM timer and the pad/driver interface.

Parameters:
- CHNL_NUM, 4, number of PWM channels handled.
- DT_WIDTH, 8, width of the dead-time counters; maximum dead band is 2^DT_WIDTH-1 cycles.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous active-low reset.
- en_i  input  CHNL_NUM  per-channel enable.
- pwm_i  input  CHNL_NUM  raw PWM from the timer.
- dt_rise_i  input  DT_WIDTH  dead cycles before the high side turns on (shared by all channels).
- dt_fall_i  input  DT_WIDTH  dead cycles before the low side turns on (shared by all channels).
- pol_i  input  2*CHNL_NUM  output polarity: bit 2c inverts high side, bit 2c+1 inverts low side. Present only with the optional feature.
- pwm_h_o  output  CHNL_NUM  high-side drive.
- pwm_l_o  output  CHNL_NUM  low-side drive.
- dt_act_o  output  CHNL_NUM  channel currently in a dead band.

Behaviour:
- Interface: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: all internal registers clear; pwm_h_o=0, pwm_l_o=0, dt_act_o=0 (before polarity, see Optional Feature). Reset mid-band aborts immediately with outputs 0 and counter 0.
- Input stage: pwm_i is registered once into pwm_q (1 cycle latency; no synchroniser, the source is synchronous).
- Per-channel FSM, 5 states. All outputs are registered from state.
  - OFF: h=0, l=0. Stays while en_i[c]=0. When en_i[c]=1, go to DB_H if pwm_q=1, else DB_L; cnt is loaded with the matching dt value.
  - DB_H: h=0, l=0, dt_act=1.
    - cnt decrements each cycle; at cnt==0 go to ON_H.
    - If pwm_q drops to 0 while in DB_H, go to DB_L and reload cnt=dt_fall_i (restart, no shortcut).
  - ON_H: h=1, l=0. When pwm_q=0, go to DB_L with cnt=dt_fall_i.
  - DB_L: mirror of DB_H, going to ON_L; a pwm_q rise goes to DB_H with cnt=dt_rise_i.
  - ON_L: h=0, l=1. When pwm_q=1, go to DB_H with cnt=dt_rise_i.
- Zero dead time: dt value 0 skips the dead band. The FSM goes straight to ON_x, and the switch from one side to the other happens in the same cycle.
- Timing: pwm_q changes at edge k. The active side deasserts at edge k+1, and the new side asserts at edge k+1+dt.
- Short pulses: a pwm pulse shorter than the dead band is swallowed; both sides stay off.
- Counter: loaded only on dead-band entry; dt_*_i changes mid-band are ignored. No wrap-around: cnt saturates at 0.
- Enable: en_i[c] falling in any state goes to OFF on the next edge, with outputs 0 and cnt cleared. en_i has priority over pwm_q changes.
- Invariant: pwm_h_o[c] and pwm_l_o[c] are never both active (pre-polarity) in any cycle.

Optional Feature:
- Macro: PWM_DEADTIME_POL_EN.
- Defined: pol_i exists. Each output is XORed with its pol bit after the output register (combinational XOR, no added latency). Reset/OFF values then equal the pol bits.
- Undefined: pol_i is absent and outputs are active-high as described above.

Decomposition:
- Package additions go in pwm_define.sv:
  - typedef enum of the FSM states: OFF, DB_H, ON_H, DB_L, ON_L.
  - Default DT_WIDTH localparam.
- Sub-module pwm_deadtime_chnl: one FSM, counter and input register per channel. The top generates CHNL_NUM instances and applies polarity.

Test Plan:
1. dt_rise=3, dt_fall=5, en=1, pwm_i square wave 20 cycles high / 20 low:
   - h rises 1+3 cycles after the pwm_q rise.
   - l rises 1+5 cycles after the pwm_q fall.
   - dt_act is high exactly 3 and 5 cycles.
2. dt_rise=dt_fall=0, same stimulus -> h and l toggle in the same cycle, dt_act never asserts, never both 1.
3. dt_rise=8, pwm_i high pulse of 4 cycles -> pulse swallowed. h stays 0; FSM goes DB_H to DB_L, and l reasserts dt_fall cycles after the fall.
4. While in DB_H with cnt=5, deassert en_i -> next edge h=l=dt_act=0 and state OFF. Re-enable with pwm_i=0 -> l asserts after dt_fall.
5. Assert rst_n_i asynchronously mid dead band -> outputs 0 immediately, without waiting for a clock edge. After release, the channel behaves as from a cold start.
6. With PWM_DEADTIME_POL_EN defined, pol_i=2'b10 on ch0 -> low side inverted (reads 1 in OFF), high side unchanged. Scoreboard invariant checked on pre-polarity values.
